// File: rtl/game_logic_n_if.sv
// rtl/game_logic_n_if.sv - move request and result bundle for the NxN 2048 move engine
interface game_logic_n_if #(
  parameter int N       = 4,
  parameter int W       = 12,
  parameter int SCORE_W = 20
);
  logic                         enable;
  logic [3:0]                   direction;
  logic [N-1:0][N-1:0][W-1:0]   matrix;
  logic [N-1:0][N-1:0][W-1:0]   matrix_D;
  logic                         ready;
  logic                         moved;
  logic                         win;
  logic                         game_over;
  logic [SCORE_W-1:0]           score;

  modport master (output enable, direction, matrix,
                  input  matrix_D, ready, moved, win, game_over, score);
  modport slave  (input  enable, direction, matrix,
                  output matrix_D, ready, moved, win, game_over, score);
endinterface

// File: rtl/game_logic_n.sv
// rtl/game_logic_n.sv - NxN 2048 move engine: one line per cycle slide/merge/slide, score and end-of-game flags
module game_logic_n #(
  parameter int N         = 4,
  parameter int W         = 12,
  parameter int WIN_VALUE = 2048,
  parameter int SCORE_W   = 20
) (
  input logic          clk,
  input logic          rst,
  game_logic_n_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef logic [N-1:0][N-1:0][W-1:0] board_t;
  typedef logic [N-1:0][W-1:0]        line_t;
  typedef enum logic [2:0] {IDLE, LOAD, LINE, CHECK, DONE} state_t;

  state_t             state;
  board_t             orig, work, work_next, res;
  logic [3:0]         dir;
  logic [CW-1:0]      cnt;
  logic [SCORE_W-1:0] delta, line_delta, score_q;
  logic               ready_q, moved_q, win_q, over_q;
  line_t              line_in, line_out;
  logic               dir_valid, win_c, pair_c, zero_c;

  assign dir_valid = $onehot(dir);

  // Each upward sweep carries every empty slot one run further toward the far end, order preserved.
  function automatic line_t compress(input line_t l);
    line_t c = l;
    for (int p = 0; p < N - 1; p++)
      for (int k = 0; k < N - 1; k++)
        if (c[k] == '0) begin
          c[k]   = c[k+1];
          c[k+1] = '0;
        end
    return c;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[SCORE_W] ? '1 : t[SCORE_W-1:0];
  endfunction

  // Index 0 of the working line is always the destination edge.
  always_comb begin
    line_in = '0;
    for (int k = 0; k < N; k++)
      case (dir)
        4'b0001: line_in[k] = work[N-1-k][cnt];
        4'b0010: line_in[k] = work[k][cnt];
        4'b0100: line_in[k] = work[cnt][N-1-k];
        4'b1000: line_in[k] = work[cnt][k];
        default: line_in[k] = '0;
      endcase
  end

  always_comb begin
    line_t      m;
    logic [W:0] s;
    m          = compress(line_in);
    line_delta = '0;
    s          = '0;
    // A merged slot becomes zero, so it can never pair again with its upper neighbour.
    for (int k = 0; k < N - 1; k++) begin
      s = {1'b0, m[k]} + {1'b0, m[k+1]};
      if (m[k] != '0 && m[k] == m[k+1] && !s[W]) begin
        m[k]       = s[W-1:0];
        m[k+1]     = '0;
        line_delta = line_delta + SCORE_W'(s);
      end
    end
    line_out = compress(m);
  end

  always_comb begin
    work_next = work;
    for (int k = 0; k < N; k++)
      case (dir)
        4'b0001: work_next[N-1-k][cnt] = line_out[k];
        4'b0010: work_next[k][cnt]     = line_out[k];
        4'b0100: work_next[cnt][N-1-k] = line_out[k];
        4'b1000: work_next[cnt][k]     = line_out[k];
        default: work_next = work;
      endcase
  end

  always_comb begin
    win_c  = 1'b0;
    zero_c = 1'b0;
    pair_c = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (work[r][c] >= W'(WIN_VALUE)) win_c = 1'b1;
        if (work[r][c] == '0) zero_c = 1'b1;
      end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N - 1; c++)
        if (work[r][c] == work[r][c+1]) pair_c = 1'b1;
    for (int r = 0; r < N - 1; r++)
      for (int c = 0; c < N; c++)
        if (work[r][c] == work[r+1][c]) pair_c = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      orig    <= '0;
      work    <= '0;
      res     <= '0;
      dir     <= '0;
      cnt     <= '0;
      delta   <= '0;
      score_q <= '0;
      ready_q <= 1'b0;
      moved_q <= 1'b0;
      win_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.enable) begin
          orig    <= bus.matrix;
          dir     <= bus.direction;
          ready_q <= 1'b0;
          state   <= LOAD;
        end
        LOAD: begin
          work  <= orig;
          cnt   <= '0;
          delta <= '0;
          state <= LINE;
        end
        LINE: begin
          if (dir_valid) begin
            work  <= work_next;
            delta <= sat_add(delta, line_delta);
          end
          if (cnt == CW'(N - 1)) state <= CHECK;
          else                   cnt   <= cnt + 1'b1;
        end
        CHECK: begin
          res     <= work;
          moved_q <= dir_valid && (work != orig);
          win_q   <= win_c;
          over_q  <= !zero_c && !pair_c;
          score_q <= sat_add(score_q, delta);
          ready_q <= 1'b1;
          state   <= DONE;
        end
        DONE: if (!bus.enable) begin
          ready_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.matrix_D  = res;
  assign bus.ready     = ready_q;
  assign bus.moved     = moved_q;
  assign bus.win       = win_q;
  assign bus.game_over = over_q;
  assign bus.score     = score_q;
endmodule

// File: tb/tb_game_logic_n.sv
// tb/tb_game_logic_n.sv - directed-vector bench for game_logic_n (N=4, W=12)
module tb_game_logic_n;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;
  int   exp_score = 0;
  logic [3:0][3:0][11:0] mat, expm;

  always #5 clk = ~clk;

  game_logic_n_if #(.N(4), .W(12), .SCORE_W(20)) bus ();
  game_logic_n #(.N(4), .W(12), .WIN_VALUE(2048), .SCORE_W(20)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [3:0][11:0] row(input int c3, input int c2, input int c1, input int c0);
    return {12'(c3), 12'(c2), 12'(c1), 12'(c0)};
  endfunction

  task automatic do_move(input logic [3:0] d, input logic [3:0][3:0][11:0] b, output int lat);
    bit got = 0;
    @(negedge clk);
    bus.direction = d;
    bus.matrix    = b;
    bus.enable    = 1'b1;
    lat = -1;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.ready) got = 1;
    end
    if (!got) lat = 99;
  endtask

  task automatic release_en();
    @(negedge clk);
    bus.enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vectors++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.ready); end
    vectors++; if (bus.score !== 20'd0) begin errors++; $display("FAIL reset_score got %0d want 0", bus.score); end
    vectors++; if (bus.matrix_D !== '0) begin errors++; $display("FAIL reset_matrix got %h want 0", bus.matrix_D); end
    vectors++; if ({bus.moved, bus.win, bus.game_over} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {bus.moved, bus.win, bus.game_over}); end
  endtask

  task automatic test_example();
    int lat;
    mat[3] = row(2, 0, 0, 0);   mat[2] = row(4, 4, 128, 128);
    mat[1] = row(8, 0, 8, 0);   mat[0] = row(16, 16, 0, 2);
    expm[3] = row(2, 0, 0, 0);  expm[2] = row(8, 256, 0, 0);
    expm[1] = row(16, 0, 0, 0); expm[0] = row(32, 2, 0, 0);
    exp_score += 312;
    do_move(4'b0100, mat, lat);
    vectors++; if (lat !== 6) begin errors++; $display("FAIL example_latency got %0d want 6", lat); end
    vectors++; if (bus.matrix_D !== expm) begin errors++; $display("FAIL example_board got %h want %h", bus.matrix_D, expm); end
    vectors++; if (bus.score !== 20'(exp_score)) begin errors++; $display("FAIL example_score got %0d want %0d", bus.score, exp_score); end
    vectors++; if ({bus.moved, bus.win, bus.game_over} !== 3'b100) begin errors++; $display("FAIL example_flags got %b want 100", {bus.moved, bus.win, bus.game_over}); end
    release_en();
    vectors++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL example_ready_drop got %b want 0", bus.ready); end
  endtask

  task automatic test_full_board();
    int lat;
    mat[3] = row(2, 128, 32, 2);   mat[2] = row(4, 8, 128, 64);
    mat[1] = row(8, 512, 8, 2);    mat[0] = row(64, 16, 1024, 32);
    do_move(4'b0010, mat, lat);
    vectors++; if (bus.matrix_D !== mat) begin errors++; $display("FAIL full_board got %h want %h", bus.matrix_D, mat); end
    vectors++; if ({bus.moved, bus.win, bus.game_over} !== 3'b001) begin errors++; $display("FAIL full_flags got %b want 001", {bus.moved, bus.win, bus.game_over}); end
    vectors++; if (bus.score !== 20'(exp_score)) begin errors++; $display("FAIL full_score got %0d want %0d", bus.score, exp_score); end
    release_en();
  endtask

  task automatic test_lines();
    int lat;
    int pulses = 0;
    // enable dropped right after the move starts: ready must pulse exactly once
    mat = '0; mat[0] = row(2, 2, 2, 0);
    expm = '0; expm[0] = row(4, 2, 0, 0);
    exp_score += 4;
    @(negedge clk);
    bus.direction = 4'b0100; bus.matrix = mat; bus.enable = 1'b1;
    @(negedge clk);
    bus.enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.ready) pulses++;
    end
    vectors++; if (pulses !== 1) begin errors++; $display("FAIL line_ready_pulse got %0d want 1", pulses); end
    vectors++; if (bus.matrix_D !== expm) begin errors++; $display("FAIL line_2220 got %h want %h", bus.matrix_D, expm); end
    vectors++; if (bus.score !== 20'(exp_score)) begin errors++; $display("FAIL line_2220_score got %0d want %0d", bus.score, exp_score); end

    mat[0] = row(4, 4, 4, 4); expm[0] = row(8, 8, 0, 0);
    exp_score += 16;
    do_move(4'b0100, mat, lat);
    vectors++; if (bus.matrix_D !== expm) begin errors++; $display("FAIL line_4444_left got %h want %h", bus.matrix_D, expm); end
    vectors++; if (bus.score !== 20'(exp_score)) begin errors++; $display("FAIL line_4444_score got %0d want %0d", bus.score, exp_score); end
    release_en();

    expm[0] = row(0, 0, 8, 8);
    exp_score += 16;
    do_move(4'b1000, mat, lat);
    vectors++; if (bus.matrix_D !== expm) begin errors++; $display("FAIL line_4444_right got %h want %h", bus.matrix_D, expm); end
    vectors++; if (bus.moved !== 1'b1) begin errors++; $display("FAIL line_right_moved got %b want 1", bus.moved); end
    release_en();
  endtask

  task automatic test_overflow();
    int lat;
    mat = '0; mat[0] = row(2048, 2048, 0, 0);
    do_move(4'b0100, mat, lat);
    vectors++; if (bus.matrix_D !== mat) begin errors++; $display("FAIL ovf_board got %h want %h", bus.matrix_D, mat); end
    vectors++; if ({bus.moved, bus.win} !== 2'b01) begin errors++; $display("FAIL ovf_flags got %b want 01", {bus.moved, bus.win}); end
    vectors++; if (bus.score !== 20'(exp_score)) begin errors++; $display("FAIL ovf_score got %0d want %0d", bus.score, exp_score); end
    release_en();

    mat[0] = row(1024, 1024, 0, 0);
    expm = '0; expm[0] = row(2048, 0, 0, 0);
    exp_score += 2048;
    do_move(4'b0100, mat, lat);
    vectors++; if (bus.matrix_D !== expm) begin errors++; $display("FAIL win_board got %h want %h", bus.matrix_D, expm); end
    vectors++; if ({bus.moved, bus.win} !== 2'b11) begin errors++; $display("FAIL win_flags got %b want 11", {bus.moved, bus.win}); end
    vectors++; if (bus.score !== 20'(exp_score)) begin errors++; $display("FAIL win_score got %0d want %0d", bus.score, exp_score); end
    release_en();
  endtask

  task automatic test_invalid_dir();
    int lat;
    mat = '0; mat[0] = row(2, 2, 0, 0); mat[1] = row(0, 8, 8, 0);
    do_move(4'b0011, mat, lat);
    vectors++; if (lat !== 6) begin errors++; $display("FAIL invalid_latency got %0d want 6", lat); end
    vectors++; if (bus.matrix_D !== mat) begin errors++; $display("FAIL invalid_board got %h want %h", bus.matrix_D, mat); end
    vectors++; if (bus.moved !== 1'b0) begin errors++; $display("FAIL invalid_moved got %b want 0", bus.moved); end
    vectors++; if (bus.score !== 20'(exp_score)) begin errors++; $display("FAIL invalid_score got %0d want %0d", bus.score, exp_score); end
    release_en();
  endtask

  task automatic test_hold_enable();
    int rises = 0;
    logic prev = 1'b0;
    mat = '0; mat[0] = row(2, 2, 0, 0);
    exp_score += 4;
    @(negedge clk);
    bus.direction = 4'b0100; bus.matrix = mat; bus.enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.ready && !prev) rises++;
      prev = bus.ready;
    end
    vectors++; if (rises !== 1) begin errors++; $display("FAIL hold_moves got %0d want 1", rises); end
    vectors++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL hold_ready got %b want 1", bus.ready); end
    vectors++; if (bus.score !== 20'(exp_score)) begin errors++; $display("FAIL hold_score got %0d want %0d", bus.score, exp_score); end
    release_en();
  endtask

  task automatic test_reset_mid();
    int lat;
    mat[3] = row(2, 0, 0, 0);   mat[2] = row(4, 4, 128, 128);
    mat[1] = row(8, 0, 8, 0);   mat[0] = row(16, 16, 0, 2);
    expm[3] = row(2, 0, 0, 0);  expm[2] = row(8, 256, 0, 0);
    expm[1] = row(16, 0, 0, 0); expm[0] = row(32, 2, 0, 0);
    @(negedge clk);
    bus.direction = 4'b0100; bus.matrix = mat; bus.enable = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    vectors++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b want 0", bus.ready); end
    vectors++; if (bus.score !== 20'd0) begin errors++; $display("FAIL rstmid_score got %0d want 0", bus.score); end
    vectors++; if (bus.matrix_D !== '0) begin errors++; $display("FAIL rstmid_board got %h want 0", bus.matrix_D); end
    bus.enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_score = 312;
    do_move(4'b0100, mat, lat);
    vectors++; if (lat !== 6) begin errors++; $display("FAIL rstmid_latency got %0d want 6", lat); end
    vectors++; if (bus.matrix_D !== expm) begin errors++; $display("FAIL rstmid_board2 got %h want %h", bus.matrix_D, expm); end
    vectors++; if (bus.score !== 20'(exp_score)) begin errors++; $display("FAIL rstmid_score2 got %0d want %0d", bus.score, exp_score); end
    release_en();
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.direction = 4'b0000;
    bus.matrix = '0;
    mat = '0;
    expm = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_example();
    test_full_board();
    test_lines();
    test_overflow();
    test_invalid_dir();
    test_hold_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
